// File: rtl/seq_dect_ctrl.sv
// seq_dect_ctrl: streams a frame MSB-first into an external 1011 detector and counts its detections
module seq_dect_ctrl #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] data_in,
  input  logic             dect_in,
  output logic             det_rst,
  output logic             seq_out,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] match_count,
  output logic             hit
);
  localparam int IW = $clog2(WIDTH);
  localparam logic [IW-1:0] LAST = IW'(WIDTH - 1);
  typedef enum logic [2:0] {IDLE, CLR, SHIFT, DRAIN, DONE} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic count_en;
  assign count_en = (state_q == SHIFT || state_q == DRAIN) && dect_in;
  always_comb begin
    state_d = state_q;
    sr_d = sr_q;
    idx_d = idx_q;
    cnt_d = (count_en && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = CLR;
        sr_d = data_in;
        idx_d = '0;
        cnt_d = '0;
      end
      CLR: state_d = SHIFT;
      SHIFT: begin
        sr_d = {sr_q[WIDTH-2:0], 1'b0};
        idx_d = idx_q + 1'b1;
        state_d = (idx_q == LAST) ? DRAIN : SHIFT;
      end
      DRAIN: state_d = DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      sr_q <= '0;
      idx_q <= '0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      sr_q <= sr_d;
      idx_q <= idx_d;
      cnt_q <= cnt_d;
    end
  end
  assign det_rst = state_q == CLR;
  assign seq_out = state_q == SHIFT && sr_q[WIDTH-1];
  assign busy = state_q != IDLE;
  assign done = state_q == DONE;
  assign match_count = cnt_q;
  assign hit = |cnt_q;
endmodule

// File: tb/tb_seq_dect_ctrl.sv
// tb_seq_dect_ctrl: drives directed frames through seq_dect_ctrl with a 1011 detector and a cycle-offset model
module tb_seq_dect_ctrl;
  localparam int W = 16;
  localparam int CW = 5;
  logic clk = 0;
  logic reset = 1;
  logic start = 0;
  logic [W-1:0] data_in = '0;
  logic dect_in, det_rst, seq_out, busy, done, hit;
  logic [CW-1:0] match_count;
  logic start2 = 0;
  logic [3:0] data2 = '0;
  logic det_rst2, seq_out2, busy2, done2, hit2;
  logic [1:0] mc2;
  int checks = 0;
  int failures = 0;
  int ph = -1;
  int m_cnt = 0;
  logic [W-1:0] m_d = '0;
  int dst = 0;
  int clr_n = 0;
  bit chk_en = 0;
  int n, b, c0, dn;
  logic [3:0] sb;
  int t_done[$];
  int t_clr[$];

  always #5 clk = ~clk;

  seq_dect_ctrl #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .start(start), .data_in(data_in), .dect_in(dect_in),
    .det_rst(det_rst), .seq_out(seq_out), .busy(busy), .done(done),
    .match_count(match_count), .hit(hit)
  );

  seq_dect_ctrl #(.WIDTH(4), .CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .start(start2), .data_in(data2), .dect_in(1'b1),
    .det_rst(det_rst2), .seq_out(seq_out2), .busy(busy2), .done(done2),
    .match_count(mc2), .hit(hit2)
  );

  // team 1011 detector: Moore output, returns to empty after each detection
  always @(posedge clk) begin
    if (reset || det_rst) dst <= 0;
    else case (dst)
      0: dst <= seq_out ? 1 : 0;
      1: dst <= seq_out ? 1 : 2;
      2: dst <= seq_out ? 3 : 0;
      3: dst <= seq_out ? 4 : 2;
      default: dst <= 0;
    endcase
  end
  assign dect_in = (dst == 4);

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      ph = -1;
      m_cnt = 0;
    end else begin
      if (ph >= 1 && ph <= W + 1 && dect_in) m_cnt = (m_cnt == (1 << CW) - 1) ? m_cnt : m_cnt + 1;
      if (ph < 0) begin
        if (start) begin
          ph = 0;
          m_cnt = 0;
          m_d = data_in;
        end
      end else ph = (ph == W + 2) ? -1 : ph + 1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (det_rst) clr_n++;
    if (chk_en) begin
      check("cyc_busy", busy, ph >= 0);
      check("cyc_det_rst", det_rst, ph == 0);
      check("cyc_seq_out", seq_out, (ph >= 1 && ph <= W) ? m_d[W-ph] : 1'b0);
      check("cyc_done", done, ph == W + 2);
      check("cyc_count", match_count, m_cnt);
      check("cyc_hit", hit, m_cnt != 0);
    end
  end

  task automatic run_frame(input logic [W-1:0] d, input int exp_cnt);
    int fn, fb;
    @(posedge clk); #1 start = 1; data_in = d;
    @(posedge clk); #1 start = 0; data_in = W'($urandom);
    fn = 0;
    fb = busy;
    while (!done && fn < 60) begin
      @(posedge clk); #1;
      fn++;
      fb += busy;
    end
    check("done_edges", fn, W + 2);
    check("busy_cycles", fb, W + 3);
    check("frame_count", match_count, exp_cnt);
    check("frame_hit", hit, exp_cnt != 0);
    @(posedge clk); #1;
    check("idle_after_done", busy, 0);
    check("count_held", match_count, exp_cnt);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_seq_out", seq_out, 0);
    check("rst_det_rst", det_rst, 0);
    check("rst_count", match_count, 0);
    check("rst_hit", hit, 0);
    chk_en = 1;
    reset = 0;
    run_frame(16'hB000, 1);
    run_frame(16'h0000, 0);
    run_frame(16'hBBBB, 2);
    run_frame(16'h000B, 1);
    @(posedge clk); #1 start = 1; data_in = 16'hB000;
    @(posedge clk); #1 start = 0;
    repeat (8) @(posedge clk);
    #1;
    check("mid_busy", busy, 1);
    check("mid_count", match_count, 1);
    #2 reset = 1;
    #1;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_seq_out", seq_out, 0);
    check("abort_det_rst", det_rst, 0);
    check("abort_count", match_count, 0);
    check("abort_hit", hit, 0);
    @(posedge clk); #1 reset = 0;
    dn = 0;
    repeat (25) begin
      @(posedge clk); #1;
      dn += done;
    end
    check("no_done_after_abort", dn, 0);
    run_frame(16'hB000, 1);
    @(posedge clk); #1 start = 1; data_in = 16'hB000;
    for (int i = 0; i < 45; i++) begin
      @(posedge clk); #1;
      if (done) t_done.push_back(i);
      if (det_rst) t_clr.push_back(i);
    end
    start = 0;
    check("held_clr_pulses", t_clr.size(), 3);
    check("held_done_pulses", t_done.size(), 2);
    check("held_idle_gap", (t_clr.size() > 1 && t_done.size() > 0) ? t_clr[1] - t_done[0] : -1, 2);
    check("held_period", (t_clr.size() > 1) ? t_clr[1] - t_clr[0] : -1, 20);
    n = 0;
    while (busy && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check("held_drain_idle", busy, 0);
    check("held_count", match_count, 1);
    c0 = clr_n;
    @(posedge clk); #1 start = 1; data_in = 16'h0000;
    @(posedge clk); #1 start = 0;
    repeat (5) @(posedge clk);
    #1 start = 1;
    @(posedge clk); #1 start = 0;
    n = 0;
    while (!done && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check("pulse_done_seen", done, 1);
    check("pulse_done_edges", n, 12);
    start = 1;
    @(posedge clk); #1 start = 0;
    b = 0;
    repeat (5) begin
      @(posedge clk); #1;
      b += busy;
    end
    check("pulse_idle", b, 0);
    check("pulse_clr_once", clr_n - c0, 1);
    @(posedge clk); #1 start2 = 1; data2 = 4'hA;
    @(posedge clk); #1 start2 = 0; data2 = 4'h0;
    check("w4_clr", det_rst2, 1);
    sb = '0;
    repeat (4) begin
      @(posedge clk); #1;
      sb = {sb[2:0], seq_out2};
    end
    check("w4_bits", sb, 4'hA);
    @(posedge clk); #1;
    check("w4_drain_seq", seq_out2, 0);
    check("w4_drain_done", done2, 0);
    @(posedge clk); #1;
    check("w4_done", done2, 1);
    check("w4_saturate", mc2, 2'd3);
    check("w4_hit", hit2, 1);
    @(posedge clk); #1;
    check("w4_idle", busy2, 0);
    check("w4_count_held", mc2, 2'd3);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/seq_dect_ctrl.md
SEQ_DECT_CTRL -- requirements
Module: seq_dect_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 16: frame length in bits, legal range 4..32.
REQ-002 SHALL have parameter CNT_W, default 5: width of match_count.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state changes on the rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port start, input, 1 bit: frame request, sampled on the rising edge.
REQ-006 SHALL have port data_in, input, WIDTH bits: frame word, captured when start is accepted.
REQ-007 SHALL have port dect_in, input, 1 bit: Moore output of the external 1011 sequence detector.
REQ-008 SHALL have port det_rst, output, 1 bit: reset to the external detector.
REQ-009 SHALL have port seq_out, output, 1 bit: serial bit stream to the detector's seq_in.
REQ-010 SHALL have port busy, output, 1 bit: high whenever the FSM is not in IDLE.
REQ-011 SHALL have port done, output, 1 bit: one-cycle frame-complete pulse.
REQ-012 SHALL have port match_count, output, CNT_W bits: detections in the last or current frame.
REQ-013 SHALL have port hit, output, 1 bit: high when match_count is nonzero.

Function
REQ-014 SHALL implement states IDLE, CLR, SHIFT, DRAIN and DONE, with all outputs decoded from registered state and data (no combinational input-to-output paths).
REQ-015 IDLE: start=1 SHALL load data_in into a WIDTH-bit shift register, clear match_count to 0, clear the bit index, and go to CLR; start=0 SHALL stay in IDLE.
REQ-016 CLR SHALL last exactly 1 cycle with det_rst=1, then go to SHIFT; det_rst SHALL be 0 in every other state.
REQ-017 SHIFT SHALL last exactly WIDTH cycles; seq_out SHALL be the shift-register MSB (data_in MSB first), and the register SHALL shift left by 1 each cycle.
REQ-018 After bit index WIDTH-1, SHIFT SHALL go to DRAIN; DRAIN SHALL last 1 cycle with seq_out=0, then go to DONE.
REQ-019 seq_out SHALL be 0 in IDLE, CLR, DRAIN and DONE.
REQ-020 In every SHIFT and DRAIN cycle, dect_in=1 SHALL increment match_count by 1 at the end of that cycle; this accounts for the detector's one-cycle Moore latency, and the DRAIN cycle captures a detection on the last bit.
REQ-021 match_count SHALL saturate at 2^CNT_W-1 and SHALL never wrap.
REQ-022 DONE SHALL last 1 cycle with done=1, then return to IDLE.
REQ-023 done SHALL go high WIDTH+2 rising edges after the edge that accepted start; total latency from start to done is WIDTH+3 cycles.
REQ-024 match_count and hit SHALL hold their value in DONE and IDLE until the next accepted start.
REQ-025 start SHALL be ignored in CLR, SHIFT, DRAIN and DONE, and data_in SHALL be don't-care outside the accepting edge.
REQ-026 start=1 held continuously SHALL begin a new frame on the edge that returns the FSM to IDLE plus one, so frames are separated by exactly one IDLE cycle.
REQ-027 busy SHALL be 1 in CLR, SHIFT, DRAIN and DONE, and 0 in IDLE.

Reset
REQ-028 reset=1 SHALL force IDLE immediately (asynchronously) from any state, including mid-SHIFT.
REQ-029 During reset, the following SHALL hold: busy=0, done=0, seq_out=0, det_rst=0, match_count=0, hit=0, shift register=0.
REQ-030 A frame aborted by reset SHALL produce no done pulse, and the next start after reset deasserts SHALL run a full frame.

Verification
REQ-031 Reset then start with data_in=16'hB000 -> busy for 19 cycles; done pulses 18 edges after start; match_count=1; hit=1.
REQ-032 data_in=16'h0000 -> match_count=0; hit=0; done still arrives after WIDTH+3 cycles.
REQ-033 data_in=16'hBBBB with the team's 1011 detector attached -> match_count=2.
REQ-034 data_in=16'h000B (detection on the final bit) -> match_count=1, counted in the DRAIN cycle.
REQ-035 Assert reset during SHIFT bit 7 -> all outputs 0 at once and no done pulse; the next frame with 16'hB000 -> match_count=1.
REQ-036 Hold start=1 with start pulses during busy -> mid-frame pulses are ignored, and back-to-back frames are separated by one IDLE cycle; det_rst pulses once per frame.
